// File: rtl/ajuste_botones_ctrl.sv
// ajuste_botones_ctrl: front-panel adjust controller for the BCD time counters.
// Synchronises and debounces the up/down/left/right buttons, tracks the selected
// time field (en_count) and emits single-cycle enUP/enDOWN pulses.
// Optional macro AUTO_REPEAT_EN: a held up/down button auto-repeats its pulse.
module ajuste_botones_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int NUM_FIELDS      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    // Button bit order: 0 up, 1 down, 2 left, 3 right
    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_LT = 2;
    localparam int B_RT = 3;

    // Parameter sanity checks at elaboration
    if (NUM_FIELDS < 1 || NUM_FIELDS > 15) begin : g_bad_fields
        $error("NUM_FIELDS must be in 1..15");
    end
    if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        ADJUST = 1'b1
    } state_t;

    logic [3:0]     btn_raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     db_q, db_prev_q;
    logic [DBW-1:0] db_cnt_q [4];
    logic [3:0]     press;

    state_t         state_q;
    logic [3:0]     field_q;
    logic [3:0]     en_count_q;
    logic           enUP_q, enDOWN_q;

    logic           up_ev, dn_ev, lt_ev, rt_ev;
    logic [3:0]     field_d;
    logic           field_chg;
    logic           pulse_up, pulse_dn;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    // Two-flop synchroniser and per-button debounce counters
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES)) begin
                    db_q[i]     <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    // A direction press counts only when the opposite button is not held
    assign up_ev = press[B_UP] & ~db_q[B_DN];
    assign dn_ev = press[B_DN] & ~db_q[B_UP];
    assign lt_ev = press[B_LT];
    assign rt_ev = press[B_RT];

    // Next field value with wrap-around; simultaneous left+right cancels
    always_comb begin
        field_d = field_q;
        if (rt_ev && !lt_ev) begin
            field_d = (field_q >= 4'(NUM_FIELDS)) ? 4'd1 : field_q + 4'd1;
        end else if (lt_ev && !rt_ev) begin
            field_d = (field_q <= 4'd1) ? 4'(NUM_FIELDS) : field_q - 4'd1;
        end
    end

    assign field_chg = (field_d != field_q);

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);

    logic          rpt_active_q, rpt_dir_up_q, rpt_first_q;
    logic [RW-1:0] rpt_cnt_q;
    logic          rpt_ok, rpt_fire;
    logic [RW-1:0] rpt_last;

    // Repeat stays armed only while its own button alone is held
    assign rpt_ok   = rpt_active_q &&
                      (rpt_dir_up_q ? (db_q[B_UP] && !db_q[B_DN])
                                    : (db_q[B_DN] && !db_q[B_UP]));
    assign rpt_last = rpt_first_q ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);
    assign rpt_fire = rpt_ok && (rpt_cnt_q == rpt_last);
    assign pulse_up = up_ev || (rpt_fire && rpt_dir_up_q);
    assign pulse_dn = dn_ev || (rpt_fire && !rpt_dir_up_q);
`else
    assign pulse_up = up_ev;
    assign pulse_dn = dn_ev;
`endif

    // Mode FSM with field register, registered outputs and repeat timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            field_q    <= 4'd1;
            en_count_q <= 4'd0;
            enUP_q     <= 1'b0;
            enDOWN_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_active_q <= 1'b0;
            rpt_dir_up_q <= 1'b0;
            rpt_first_q  <= 1'b0;
            rpt_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    en_count_q <= 4'd0;
                    enUP_q     <= 1'b0;
                    enDOWN_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
                    rpt_active_q <= 1'b0;
                    rpt_cnt_q    <= '0;
`endif
                    if (prog_mode) begin
                        state_q    <= ADJUST;
                        field_q    <= 4'd1;
                        en_count_q <= 4'd1;
                    end
                end
                ADJUST: begin
                    if (!prog_mode) begin
                        state_q    <= IDLE;
                        en_count_q <= 4'd0;
                        enUP_q     <= 1'b0;
                        enDOWN_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rpt_active_q <= 1'b0;
                        rpt_cnt_q    <= '0;
`endif
                    end else begin
                        field_q    <= field_d;
                        en_count_q <= field_d;
                        enUP_q     <= pulse_up && !enUP_q;
                        enDOWN_q   <= pulse_dn && !enDOWN_q;
`ifdef AUTO_REPEAT_EN
                        if (up_ev || dn_ev) begin
                            rpt_active_q <= 1'b1;
                            rpt_dir_up_q <= up_ev;
                            rpt_first_q  <= 1'b1;
                            rpt_cnt_q    <= '0;
                        end else if (!rpt_ok) begin
                            rpt_active_q <= 1'b0;
                            rpt_cnt_q    <= '0;
                        end else if (rpt_fire) begin
                            rpt_first_q <= 1'b0;
                            rpt_cnt_q   <= '0;
                        end else if (field_chg) begin
                            rpt_cnt_q <= '0;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + 1'b1;
                        end
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_count = en_count_q;
    assign enUP     = enUP_q;
    assign enDOWN   = enDOWN_q;

endmodule

// File: doc/ajuste_botones_ctrl.md
Name: ajuste_botones_ctrl

Overview:
Front-panel adjust controller, directly upstream of the 2-digit BCD up/down counters (seconds/minutes/hours fields).
- Synchronizes and debounces four push-buttons.
- Tracks which time field is selected and presents it as a 4-bit field code on en_count.
- Emits single-cycle enUP/enDOWN pulses, with optional auto-repeat, that the counters edge-detect.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (10 ms @ 100 MHz)
REPEAT_DELAY, 50000000, cycles a held up/down button waits before the first repeat pulse
REPEAT_RATE, 10000000, cycles between subsequent repeat pulses
NUM_FIELDS, 3, number of selectable fields, 1..15; field codes 1..NUM_FIELDS

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
prog_mode  input  1  1 = adjust mode active
btn_up  input  1  raw asynchronous button, active-high
btn_down  input  1  raw asynchronous button, active-high
btn_left  input  1  raw asynchronous button, active-high
btn_right  input  1  raw asynchronous button, active-high
en_count  output  4  selected field code; 0 = none selected
enUP  output  1  one-cycle increment pulse, registered
enDOWN  output  1  one-cycle decrement pulse, registered

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset state: en_count=0, enUP=0, enDOWN=0, internal field register=1, debounced levels=0, all timers=0.
- Synchronization: each raw button passes through 2 flops.
- Debounce, per button:
  - A counter runs while the synchronized level differs from the debounced level; it clears whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips.
  - A press event is a debounced 0->1 transition.
- Latency: raw input settling high at edge t gives press event at t+2+DEBOUNCE_CYCLES and output pulse at t+3+DEBOUNCE_CYCLES.
- Mode FSM, states IDLE and ADJUST:
  - IDLE -> ADJUST when prog_mode=1. Field register is loaded with 1.
  - ADJUST -> IDLE when prog_mode=0, effective the next cycle. Any pending repeat is cancelled.
  - In IDLE: en_count=0; enUP/enDOWN are held 0 and all press events are discarded.
  - In ADJUST: en_count = field register.
- Field select, ADJUST only:
  - right press: field+1, wraps NUM_FIELDS -> 1.
  - left press: field-1, wraps 1 -> NUM_FIELDS.
  - left and right press events in the same cycle: field unchanged.
- Up/down, ADJUST only:
  - up press event: enUP=1 for exactly one cycle.
  - down press event: enDOWN=1 for exactly one cycle.
  - up and down press events in the same cycle, or up/down event while the other button is debounced-high: no pulse.
  - enUP and enDOWN are never high together; every pulse is followed by at least one low cycle.
- Field change while up/down is held: the repeat timer restarts from 0. No pulse is issued by the change itself.
- Reset mid-operation: all state returns to reset values the following cycle, and any pulse in flight is dropped.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: while up (or down) stays debounced-high in ADJUST, one further pulse is issued REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_RATE cycles until release. Release stops repeats immediately.
- Not defined: exactly one pulse per press regardless of hold time. Repeat timers and the REPEAT_* parameters are unused.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, NUM_FIELDS=3.
1. Reset asserted 3 cycles, prog_mode=0, all buttons toggling -> en_count=0, enUP=enDOWN=0 throughout.
2. prog_mode=1, btn_up held high from cycle 10 -> en_count=1; enUP high only at cycle 17, one cycle wide. Bouncing btn_up (high 2 cycles, low 1, repeated) -> no pulse.
3. prog_mode=1, four clean btn_right presses -> en_count sequence 1,2,3,1,2. Two btn_left presses from field 1 -> 3, then 2.
4. btn_up and btn_down rising in the same cycle -> no enUP, no enDOWN. btn_left/btn_right together -> en_count unchanged.
5. With AUTO_REPEAT_EN, btn_down held 50 cycles after debounce -> enDOWN pulses at offsets 0, 20, 25, 30, 35, 40, 45 from the first pulse; none after release. Without the macro -> a single pulse.
6. Reset asserted for 1 cycle while in ADJUST with field=3 and up held -> next cycle en_count=0 and enUP=0. After reset, with prog_mode still 1 -> en_count=1.
